stall_ctrl_gen: RTL and testbench

- Parametrised successor of the pipeline stall controller for the 5-stage RV32I core.
- Resolves N stall sources into a per-stage stall vector, with priority or OR-merge mode.
- Adds behaviour the combinational controller lacks: minimum-hold extension of selected requests, deferred flush sequencing behind the highest-priority source, a stall watchdog, and a stall-cycle performance counter.
- Sits beside IF/ID/EX/MEM/WB and drives every stage's stall and flush inputs.

---
 rtl/stall_ctrl_gen_pkg.sv | 23 ++
 rtl/stall_ctrl_gen_hold_ctr.sv | 26 ++
 rtl/stall_ctrl_gen.sv | 79 +++++++
 tb/tb_stall_ctrl_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stall_ctrl_gen_pkg.sv
// stall_ctrl_gen_pkg: stage indices, stall bus type and default masks for the stall controller
package stall_ctrl_gen_pkg;
   localparam int STALL_W = 7;
   localparam int STG_INT_MA = 0;
   localparam int STG_IF = 1;
   localparam int STG_ID = 2;
   localparam int STG_EX = 3;
   localparam int STG_MEM = 4;
   localparam int STG_WB = 5;
   localparam int STG_INT_IF = 6;
   typedef logic [STALL_W-1:0] stall_bus_t;
   function automatic stall_bus_t stg(input int s);
      return stall_bus_t'(1) << s;
   endfunction
   localparam stall_bus_t zero7 = '0;
   localparam stall_bus_t MASK_MEM_MA = stg(STG_INT_MA) | stg(STG_IF) | stg(STG_ID) | stg(STG_EX) | stg(STG_MEM) | stg(STG_INT_IF);
   localparam stall_bus_t MASK_ID_DATA = stg(STG_IF) | stg(STG_ID);
   localparam stall_bus_t MASK_IF_B = stg(STG_ID);
   localparam stall_bus_t MASK_IF_MEM = stg(STG_IF);
   localparam logic [4*STALL_W-1:0] DEF_SRC_MASK = {MASK_IF_MEM, MASK_IF_B, MASK_ID_DATA, MASK_MEM_MA};
   localparam stall_bus_t DEF_RDY_MASK = stg(STG_IF) | stg(STG_ID) | stg(STG_EX) | stg(STG_MEM) | stg(STG_WB);
   localparam stall_bus_t DEF_FLUSH_MASK = stg(STG_IF) | stg(STG_ID);
endpackage

// File: rtl/stall_ctrl_gen_hold_ctr.sv
// stall_hold_ctr: rising-edge detect plus minimum-hold extension for one stall source
module stall_hold_ctr #(
   parameter bit HOLD = 1'b0,
   parameter int MIN_STALL = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   input  logic req,
   output logic eff
);
   localparam int CW = $clog2(MIN_STALL + 1);
   logic req_q;
   logic [CW-1:0] cnt;
   // Everything freezes while rdy is low, so a hold resumes where it left off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q <= 1'b0;
         cnt <= '0;
      end else if (rdy) begin
         req_q <= req;
         cnt <= (HOLD && req && !req_q) ? CW'(MIN_STALL - 1) : (cnt != '0) ? cnt - 1'b1 : cnt;
      end
   end
   assign eff = req | (cnt != '0);
endmodule

// File: rtl/stall_ctrl_gen.sv
// stall_ctrl_gen: resolves stall sources into per-stage stall/flush, with watchdog and stall counter
module stall_ctrl_gen
   import stall_ctrl_gen_pkg::*;
#(
   parameter int STAGES = STALL_W,
   parameter int SRC = 4,
   parameter logic [SRC*STAGES-1:0] SRC_MASK = DEF_SRC_MASK,
   parameter logic [STAGES-1:0] RDY_MASK = DEF_RDY_MASK,
   parameter int MERGE = 0,
   parameter logic [SRC-1:0] HOLD_MASK = 4'b0100,
   parameter int MIN_STALL = 2,
   parameter logic [STAGES-1:0] FLUSH_MASK = DEF_FLUSH_MASK,
   parameter int WDOG_LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   input  logic [SRC-1:0] req,
   input  logic flush_in,
   input  logic perf_clr,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic [$clog2(SRC)-1:0] active_src,
   output logic active_vld,
   output logic wdog_err,
   output logic [31:0] stall_cnt
);
   localparam int AW = $clog2(SRC);
   localparam int WW = $clog2(WDOG_LIMIT + 2);
   logic [SRC-1:0] eff;
   logic [STAGES-1:0] pri, any_or;
   logic [AW-1:0] win;
   logic flush_pend, fl, stalled;
   logic [WW-1:0] wcnt, wnext;
   for (genvar g = 0; g < SRC; g++) begin : g_hold
      stall_hold_ctr #(.HOLD(HOLD_MASK[g]), .MIN_STALL(MIN_STALL)) u_hold (
         .clk(clk), .rst(rst), .rdy(rdy), .req(req[g]), .eff(eff[g])
      );
   end
   // Walk downwards so the lowest effective index wins the priority select.
   always_comb begin
      pri = '0;
      any_or = '0;
      win = '0;
      for (int i = SRC - 1; i >= 0; i--) begin
         if (eff[i]) begin
            pri = SRC_MASK[i*STAGES +: STAGES];
            win = AW'(i);
         end
      end
      for (int i = 0; i < SRC; i++) begin
         if (eff[i]) any_or = any_or | SRC_MASK[i*STAGES +: STAGES];
      end
   end
   // A flush waits behind the top-priority source so it never cuts a memory stall short.
   assign fl = rst & rdy & ~eff[0] & (flush_in | flush_pend);
   assign stall = !rst ? '0 : !rdy ? RDY_MASK : ((MERGE != 0) ? any_or : pri) & ~(fl ? FLUSH_MASK : '0);
   assign flush = fl ? FLUSH_MASK : '0;
   assign active_vld = rst & rdy & (|eff);
   assign active_src = rst ? win : '0;
   assign stalled = rdy & (|stall);
   assign wnext = !stalled ? '0 : (wcnt == WW'(WDOG_LIMIT)) ? wcnt : wcnt + 1'b1;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_pend <= 1'b0;
         wcnt <= '0;
         wdog_err <= 1'b0;
         stall_cnt <= '0;
      end else begin
         flush_pend <= ~fl & (flush_pend | flush_in);
         if (rdy) begin
            wcnt <= wnext;
            if (WDOG_LIMIT != 0 && wnext == WW'(WDOG_LIMIT)) wdog_err <= 1'b1;
         end
         if (perf_clr) stall_cnt <= '0;
         else if (stalled && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_stall_ctrl_gen.sv
// tb_stall_ctrl_gen: directed stimulus on priority and merge instances, checked against a spec-level model
module tb_stall_ctrl_gen;
   localparam logic [6:0] SM [4] = '{7'b1011111, 7'b0000110, 7'b0000100, 7'b0000010};
   localparam logic [6:0] RM = 7'b0111110;
   localparam logic [6:0] FM = 7'b0000110;
   localparam logic [3:0] HM = 4'b0100;
   localparam int MINS = 2;
   localparam int LIM = 8;
   logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, flush_in = 1'b0, perf_clr = 1'b0;
   logic [3:0] req = 4'h0;
   logic [6:0] st [2], fl [2];
   logic [1:0] src [2];
   logic vld [2], err [2];
   logic [31:0] cnt [2];
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   stall_ctrl_gen #(.SRC_MASK({SM[3], SM[2], SM[1], SM[0]}), .MERGE(0), .WDOG_LIMIT(LIM)) m0 (
      .clk(clk), .rst(rst), .rdy(rdy), .req(req), .flush_in(flush_in), .perf_clr(perf_clr),
      .stall(st[0]), .flush(fl[0]), .active_src(src[0]), .active_vld(vld[0]), .wdog_err(err[0]), .stall_cnt(cnt[0]));
   stall_ctrl_gen #(.SRC_MASK({SM[3], SM[2], SM[1], SM[0]}), .MERGE(1), .WDOG_LIMIT(LIM)) m1 (
      .clk(clk), .rst(rst), .rdy(rdy), .req(req), .flush_in(flush_in), .perf_clr(perf_clr),
      .stall(st[1]), .flush(fl[1]), .active_src(src[1]), .active_vld(vld[1]), .wdog_err(err[1]), .stall_cnt(cnt[1]));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   // Spec-level model: holds tracked as "rdy cycles since last rise", counters as plain integers.
   int t = 0;
   int lr [4] = '{-100, -100, -100, -100};
   logic [3:0] preq = '0;
   logic pend = 1'b0;
   int consec [2] = '{0, 0};
   logic merr [2] = '{1'b0, 1'b0};
   longint mcnt [2] = '{0, 0};
   always @(negedge clk) begin
      logic [3:0] e;
      logic f;
      logic [6:0] es, pv, ov;
      int lo;
      if (!rst) begin
         for (int m = 0; m < 2; m++) begin
            chk("rst_stall", 32'(st[m]), 0);
            chk("rst_flush", 32'(fl[m]), 0);
            chk("rst_vld", 32'(vld[m]), 0);
            chk("rst_err", 32'(err[m]), 0);
            chk("rst_cnt", cnt[m], 0);
            consec[m] = 0;
            merr[m] = 1'b0;
            mcnt[m] = 0;
         end
         t = 0;
         for (int i = 0; i < 4; i++) lr[i] = -100;
         preq = '0;
         pend = 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) e[i] = req[i] | (HM[i] && (t - lr[i]) < MINS);
         f = (flush_in | pend) & rdy & ~e[0];
         lo = -1;
         pv = '0;
         ov = '0;
         for (int i = 0; i < 4; i++) begin
            if (e[i]) begin
               if (lo < 0) begin
                  lo = i;
                  pv = SM[i];
               end
               ov = ov | SM[i];
            end
         end
         for (int m = 0; m < 2; m++) begin
            es = !rdy ? RM : ((m == 1) ? ov : pv) & ~(f ? FM : 7'b0);
            chk("stall", 32'(st[m]), 32'(es));
            chk("flush", 32'(fl[m]), f ? 32'(FM) : 0);
            chk("vld", 32'(vld[m]), 32'(rdy && e != 0));
            if (rdy && e != 0) chk("src", 32'(src[m]), 32'(lo));
            chk("wdog", 32'(err[m]), 32'(merr[m]));
            chk("cnt", cnt[m], mcnt[m][31:0]);
            if (rdy) begin
               consec[m] = (es != 0) ? ((consec[m] < LIM) ? consec[m] + 1 : LIM) : 0;
               if (consec[m] == LIM) merr[m] = 1'b1;
            end
            if (perf_clr) mcnt[m] = 0;
            else if (rdy && es != 0 && mcnt[m] < 64'hFFFF_FFFF) mcnt[m]++;
         end
         if (rdy) begin
            for (int i = 0; i < 4; i++) if (HM[i] && req[i] && !preq[i]) lr[i] = t;
            preq = req;
            t++;
         end
         pend = !f & (pend | flush_in);
      end
   end
   task automatic step(input logic r, input logic [3:0] q, input logic fi, input logic pc);
      @(posedge clk);
      #1;
      rdy = r;
      req = q;
      flush_in = fi;
      perf_clr = pc;
      @(negedge clk);
      #1;
   endtask
   int ns;
   logic [31:0] c_frz;
   initial begin
      req = 4'hF;
      flush_in = 1'b1;
      #3;
      chk("reset_stall", 32'(st[0]), 0);
      chk("reset_flush", 32'(fl[0]), 0);
      chk("reset_vld", 32'(vld[1]), 0);
      repeat (2) @(posedge clk);
      #1;
      req = 4'h0;
      flush_in = 1'b0;
      rst = 1'b1;
      step(1, 4'b0000, 0, 0);
      chk("idle_stall", 32'(st[0]), 0);
      chk("idle_vld", 32'(vld[0]), 0);
      chk("idle_cnt", cnt[0], 0);
      step(1, 4'b0011, 0, 0);
      chk("pri_0011", 32'(st[0]), 32'(7'b1011111));
      chk("pri_0011_src", 32'(src[0]), 0);
      chk("or_0011", 32'(st[1]), 32'(7'b1011111));
      step(1, 4'b1010, 0, 0);
      chk("pri_1010", 32'(st[0]), 32'(7'b0000110));
      chk("pri_1010_src", 32'(src[0]), 1);
      chk("or_1010", 32'(st[1]), 32'(7'b0000110));
      step(1, 4'b1100, 0, 0);
      chk("pri_1100", 32'(st[0]), 32'(7'b0000100));
      chk("or_1100", 32'(st[1]), 32'(7'b0000110));
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0000, 0, 0);
      step(1, 4'b0100, 0, 0);
      chk("pulse_c0", 32'(st[0]), 32'(7'b0000100));
      step(1, 4'b0000, 0, 0);
      chk("pulse_c1", 32'(st[0]), 32'(7'b0000100));
      step(1, 4'b0000, 0, 0);
      chk("pulse_c2", 32'(st[0]), 0);
      ns = 0;
      foreach (SM[k]) begin
         step(1, (k == 0 || k == 2) ? 4'b0100 : 4'b0000, 0, 0);
         ns += int'(st[0] != 0);
      end
      step(1, 4'b0000, 0, 0);
      ns += int'(st[0] != 0);
      chk("pulse_idle_pulse", 32'(ns), 4);
      step(1, 4'b0001, 1, 0);
      chk("flush_blk0", 32'(fl[0]), 0);
      step(1, 4'b0001, 0, 0);
      chk("flush_blk1", 32'(fl[0]), 0);
      step(1, 4'b0001, 0, 0);
      chk("flush_blk2", 32'(fl[0]), 0);
      step(1, 4'b0010, 0, 0);
      chk("flush_go", 32'(fl[0]), 32'(7'b0000110));
      chk("flush_go_stall", 32'(st[0]), 0);
      step(1, 4'b0000, 0, 0);
      chk("flush_once", 32'(fl[0]), 0);
      step(1, 4'b0100, 0, 0);
      step(0, 4'b0000, 0, 0);
      c_frz = cnt[0];
      chk("rdy0_stall", 32'(st[0]), 32'(7'b0111110));
      chk("rdy0_vld", 32'(vld[0]), 0);
      repeat (4) step(0, 4'b0000, 0, 0);
      chk("rdy0_cnt_frozen", cnt[0], c_frz);
      step(1, 4'b0000, 0, 0);
      chk("hold_resume", 32'(st[0]), 32'(7'b0000100));
      step(1, 4'b0000, 0, 0);
      chk("hold_done", 32'(st[0]), 0);
      step(0, 4'b0000, 1, 0);
      chk("rdy0_flush", 32'(fl[0]), 0);
      step(1, 4'b0000, 0, 0);
      chk("pend_flush", 32'(fl[0]), 32'(7'b0000110));
      step(1, 4'b0001, 1, 0);
      step(1, 4'b0000, 1, 0);
      chk("pend_plus_in", 32'(fl[0]), 32'(7'b0000110));
      step(1, 4'b0000, 0, 0);
      chk("pend_single", 32'(fl[0]), 0);
      step(1, 4'b0000, 0, 1);
      step(1, 4'b0000, 0, 0);
      chk("perf_clr", cnt[0], 0);
      repeat (8) step(1, 4'b1000, 0, 0);
      chk("wdog_pre", 32'(err[0]), 0);
      step(1, 4'b1000, 0, 0);
      chk("wdog_set", 32'(err[0]), 1);
      chk("cnt_8", cnt[0], 8);
      step(1, 4'b1000, 0, 1);
      chk("cnt_9", cnt[1], 9);
      step(1, 4'b0000, 0, 0);
      chk("perf_clr_stalled", cnt[0], 0);
      chk("wdog_sticky", 32'(err[0]), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("areset_err", 32'(err[0]), 0);
      chk("areset_cnt", cnt[1], 0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
